// File: rtl/ysyx_24110015_mem2axi_pkg.sv
// Shared types for the mem2axi bridge:
// FSM state encoding and AXI response codes.
package ysyx_24110015_mem2axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only a plain OKAY counts as success; EXOKAY has no
  // meaning for a non-exclusive AXI-Lite access.
  function automatic logic resp_err(input logic [1:0] r);
    return (r == RESP_EXOKAY) ||
           (r == RESP_SLVERR) ||
           (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ysyx_24110015_mem2axi_if.sv
// Upstream request/response bundle and AXI4-Lite
// master bundle used by the mem2axi bridge.
interface ysyx_24110015_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );
endinterface

interface ysyx_24110015_axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata,
    output wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata,
    input  wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_mem2axi_reg.sv
// Width-parameterised enable register with
// asynchronous active-high reset.
module ysyx_24110015_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_24110015_mem2axi.sv
// Single-outstanding bridge from a valid/ready
// memory request port to an AXI4-Lite master.
import ysyx_24110015_mem2axi_pkg::*;

module ysyx_24110015_mem2axi (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_24110015_mem_if.slave         mem,
  ysyx_24110015_axi_if.master        axi
);

  state_t state;
  state_t state_n;

  logic        req_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_done;
  logic        w_done;
  logic        aw_fin;
  logic        w_fin;
  logic        r_cap;
  logic        b_cap;
  logic        rsp_cap;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wen_q;
  logic [31:0] rdata_d;
  logic        err_d;

  assign req_hs = mem.req_valid & mem.req_ready;
  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;
  assign r_cap  = (state == S_R) & axi.rvalid;
  assign b_cap  = (state == S_B) & axi.bvalid;
  assign rsp_cap = r_cap | b_cap;

  ysyx_24110015_Reg #(.WIDTH(32)) u_addr (
    .clk(clk), .rst(rst), .din(mem.req_addr),
    .dout(addr_q), .wen(req_hs)
  );

  ysyx_24110015_Reg #(.WIDTH(32)) u_wdata (
    .clk(clk), .rst(rst), .din(mem.req_wdata),
    .dout(wdata_q), .wen(req_hs)
  );

  ysyx_24110015_Reg #(.WIDTH(4)) u_wstrb (
    .clk(clk), .rst(rst), .din(mem.req_wstrb),
    .dout(wstrb_q), .wen(req_hs)
  );

  ysyx_24110015_Reg #(.WIDTH(1)) u_wen (
    .clk(clk), .rst(rst), .din(mem.req_wen),
    .dout(wen_q), .wen(req_hs)
  );

  // Writes report zero data; the error bit comes
  // from whichever response channel closed the op.
  assign rdata_d = wen_q ? 32'h0 : axi.rdata;
  assign err_d   = wen_q ? resp_err(axi.bresp)
                         : resp_err(axi.rresp);

  ysyx_24110015_Reg #(.WIDTH(32)) u_rdata (
    .clk(clk), .rst(rst), .din(rdata_d),
    .dout(mem.rsp_rdata), .wen(rsp_cap)
  );

  ysyx_24110015_Reg #(.WIDTH(1)) u_err (
    .clk(clk), .rst(rst), .din(err_d),
    .dout(mem.rsp_err), .wen(rsp_cap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // AW and W finish independently; each flag keeps
  // its valid low until both sides are through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != S_AW_W ||
                 (aw_fin && w_fin)) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_fin;
      w_done  <= w_fin;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (mem.req_valid)
          state_n = mem.req_wen ? S_AW_W : S_AR;
      end
      S_AR: begin
        if (axi.arready) state_n = S_R;
      end
      S_R: begin
        if (axi.rvalid) state_n = S_RSP;
      end
      S_AW_W: begin
        if (aw_fin && w_fin) state_n = S_B;
      end
      S_B: begin
        if (axi.bvalid) state_n = S_RSP;
      end
      S_RSP: begin
        if (mem.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Valids come straight from state and done flags,
  // never from a ready input.
  assign mem.req_ready = (state == S_IDLE);
  assign mem.rsp_valid = (state == S_RSP);

  assign axi.arvalid = (state == S_AR);
  assign axi.rready  = (state == S_R);
  assign axi.awvalid = (state == S_AW_W) & ~aw_done;
  assign axi.wvalid  = (state == S_AW_W) & ~w_done;
  assign axi.bready  = (state == S_B);

  assign axi.araddr = addr_q;
  assign axi.awaddr = addr_q;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wstrb_q;

endmodule

// File: tb/tb_ysyx_24110015_mem2axi.sv
// Directed bench for the mem2axi bridge with a
// delay-programmable AXI4-Lite slave model.
module tb_ysyx_24110015_mem2axi;
  import ysyx_24110015_mem2axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24110015_mem_if mem ();
  ysyx_24110015_axi_if axi ();

  ysyx_24110015_mem2axi dut (
    .clk(clk),
    .rst(rst),
    .mem(mem),
    .axi(axi)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  int          cfg_ar_d = 0;
  int          cfg_aw_d = 0;
  int          cfg_w_d  = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  logic        stray = 1'b0;

  int ar_cnt, aw_cnt, w_cnt;
  bit r_pend, b_pend, aw_got, w_got;
  int n_ar, n_r, n_aw, n_w, n_b;
  int stab_bad, aw_held, w_held;
  logic [31:0] g_ara, g_awa, g_wd;
  logic [3:0]  g_ws;
  bit          p_arv, p_awv, p_wv;
  logic [31:0] p_ara, p_awa, p_wd;
  logic [3:0]  p_ws;

  // Slave acts on the falling edge: readies set here
  // are sampled by the DUT on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      r_pend = 0; b_pend = 0;
      aw_got = 0; w_got = 0;
      p_arv = 0; p_awv = 0; p_wv = 0;
      axi.arready = 0; axi.awready = 0;
      axi.wready = 0; axi.rvalid = 0;
      axi.bvalid = 0; axi.rdata = 0;
      axi.rresp = 0; axi.bresp = 0;
    end else begin
      if (r_pend) begin
        axi.rvalid = 1; axi.rdata = cfg_rdata;
        axi.rresp = cfg_resp;
        if (axi.rready) begin n_r++; r_pend = 0; end
      end else begin
        axi.rvalid = stray;
        axi.rdata = 32'hFFFF_FFFF;
        axi.rresp = RESP_DECERR;
      end
      if (b_pend) begin
        axi.bvalid = 1; axi.bresp = cfg_resp;
        if (axi.bready) begin n_b++; b_pend = 0; end
      end else begin
        axi.bvalid = stray;
        axi.bresp = RESP_DECERR;
      end
      if (p_arv && !(axi.arvalid &&
          axi.araddr == p_ara)) stab_bad++;
      if (p_awv && !(axi.awvalid &&
          axi.awaddr == p_awa)) stab_bad++;
      if (p_wv && !(axi.wvalid && axi.wdata == p_wd
          && axi.wstrb == p_ws)) stab_bad++;
      p_arv = 0; p_awv = 0; p_wv = 0;
      axi.arready = 0; axi.awready = 0;
      axi.wready = 0;
      if (axi.arvalid) begin
        if (ar_cnt >= cfg_ar_d) begin
          axi.arready = 1; n_ar++;
          g_ara = axi.araddr; r_pend = 1; ar_cnt = 0;
        end else begin
          ar_cnt++; p_arv = 1; p_ara = axi.araddr;
        end
      end
      if (axi.awvalid) begin
        if (aw_cnt >= cfg_aw_d) begin
          axi.awready = 1; n_aw++; aw_got = 1;
          g_awa = axi.awaddr; aw_held = aw_cnt + 1;
          aw_cnt = 0;
        end else begin
          aw_cnt++; p_awv = 1; p_awa = axi.awaddr;
        end
      end
      if (axi.wvalid) begin
        if (w_cnt >= cfg_w_d) begin
          axi.wready = 1; n_w++; w_got = 1;
          g_wd = axi.wdata; g_ws = axi.wstrb;
          w_held = w_cnt + 1; w_cnt = 0;
        end else begin
          w_cnt++; p_wv = 1;
          p_wd = axi.wdata; p_ws = axi.wstrb;
        end
      end
      if (aw_got && w_got) begin
        b_pend = 1; aw_got = 0; w_got = 0;
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_d;
    int          aw_d;
    int          w_d;
    logic [1:0]  resp;
    logic [31:0] sdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  // exp_lat counts cycles from the accept cycle up to
  // and including the response handshake cycle.
  task automatic run_vec(input vec_t v, input int id);
    int n, k, held, hold_bad;
    int b_ar, b_r, b_aw, b_w, b_b, b_st;
    bit done;
    string t;
    t = $sformatf("v%0d", id);
    @(negedge clk);
    cfg_ar_d = v.ar_d; cfg_aw_d = v.aw_d;
    cfg_w_d = v.w_d; cfg_resp = v.resp;
    cfg_rdata = v.sdata;
    b_ar = n_ar; b_r = n_r; b_aw = n_aw;
    b_w = n_w; b_b = n_b; b_st = stab_bad;
    mem.req_valid = 1; mem.req_wen = v.wen;
    mem.req_addr = v.addr; mem.req_wdata = v.wdata;
    mem.req_wstrb = v.wstrb; mem.rsp_ready = 0;
    n = 0;
    while (!mem.req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    chk({t, " accept"}, 32'(mem.req_ready), 1);
    @(posedge clk);
    k = 0; held = 0; hold_bad = 0; done = 0;
    while (!done && k < 60) begin
      @(negedge clk); k++;
      mem.req_valid = 0;
      if (mem.rsp_valid) begin
        if (held < v.hold) begin
          held++;
          if (mem.rsp_rdata !== v.exp_rdata ||
              mem.rsp_err !== v.exp_err ||
              mem.req_ready || axi.arvalid ||
              axi.awvalid || axi.wvalid)
            hold_bad++;
        end else begin
          mem.rsp_ready = 1; done = 1;
        end
      end
    end
    chk({t, " rsp seen"}, 32'(done), 1);
    chk({t, " rdata"}, mem.rsp_rdata, v.exp_rdata);
    chk({t, " err"}, 32'(mem.rsp_err),
        32'(v.exp_err));
    if (v.exp_lat != 0)
      chk({t, " latency"}, k + 1, v.exp_lat);
    if (v.hold != 0) begin
      chk({t, " held"}, held, v.hold);
      chk({t, " hold stable"}, hold_bad, 0);
    end
    if (v.wen) begin
      chk({t, " aw count"}, n_aw - b_aw, 1);
      chk({t, " w count"}, n_w - b_w, 1);
      chk({t, " b count"}, n_b - b_b, 1);
      chk({t, " awaddr"}, g_awa, v.addr);
      chk({t, " wdata"}, g_wd, v.wdata);
      chk({t, " wstrb"}, 32'(g_ws), 32'(v.wstrb));
      chk({t, " aw held"}, aw_held, v.aw_d + 1);
      chk({t, " w held"}, w_held, v.w_d + 1);
    end else begin
      chk({t, " ar count"}, n_ar - b_ar, 1);
      chk({t, " r count"}, n_r - b_r, 1);
      chk({t, " araddr"}, g_ara, v.addr);
    end
    chk({t, " stability"}, stab_bad - b_st, 0);
    @(posedge clk); #1;
    mem.rsp_ready = 0;
    chk({t, " back idle"}, 32'(mem.req_ready), 1);
    chk({t, " rsp drop"}, 32'(mem.rsp_valid), 0);
  endtask

  initial begin
    int bad;
    vec_t rv;
    vecs[0] = '{0, 32'h8000_0010, 0, 0, 0, 0, 0,
      RESP_OKAY, 32'hDEAD_BEEF, 0,
      32'hDEAD_BEEF, 0, 4};
    vecs[1] = '{1, 32'h8000_0020, 32'h1234_5678,
      4'b0011, 0, 2, 0, RESP_OKAY, 0, 0, 0, 0, 6};
    vecs[2] = '{1, 32'h8000_0100, 32'hA5A5_5A5A,
      4'b1111, 0, 0, 3, RESP_OKAY, 0, 0, 0, 0, 7};
    vecs[3] = '{1, 32'h8000_0104, 32'h0BAD_F00D,
      4'b1000, 0, 0, 0, RESP_OKAY, 0, 0, 0, 0, 4};
    vecs[4] = '{0, 32'h8000_0200, 0, 0, 0, 0, 0,
      RESP_SLVERR, 32'h1111_2222, 0,
      32'h1111_2222, 1, 4};
    vecs[5] = '{1, 32'h8000_0204, 32'h5555_AAAA,
      4'b0101, 0, 0, 0, RESP_DECERR, 0, 0, 0, 1, 4};
    vecs[6] = '{0, 32'h8000_0300, 0, 0, 0, 0, 0,
      RESP_OKAY, 32'hCAFE_0001, 5,
      32'hCAFE_0001, 0, 9};
    vecs[7] = '{0, 32'h8000_0304, 0, 0, 2, 0, 0,
      RESP_EXOKAY, 32'h0000_00FF, 0,
      32'h0000_00FF, 1, 6};
    vecs[8] = '{1, 32'h8000_0308, 32'hFFFF_0000,
      4'b1100, 0, 1, 1, RESP_EXOKAY, 0, 0, 0, 1, 5};

    mem.req_valid = 0; mem.req_wen = 0;
    mem.req_addr = 0; mem.req_wdata = 0;
    mem.req_wstrb = 0; mem.rsp_ready = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst req_ready", 32'(mem.req_ready), 1);
    chk("rst rsp_valid", 32'(mem.rsp_valid), 0);
    chk("rst rsp_rdata", mem.rsp_rdata, 0);
    chk("rst rsp_err", 32'(mem.rsp_err), 0);
    chk("rst valids", {27'h0, axi.arvalid,
        axi.awvalid, axi.wvalid, axi.rready,
        axi.bready}, 0);
    chk("rst araddr", axi.araddr, 0);
    chk("rst awaddr", axi.awaddr, 0);
    chk("rst wdata", axi.wdata, 0);
    chk("rst wstrb", 32'(axi.wstrb), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Stray R/B valids while idle must be ignored.
    @(negedge clk);
    stray = 1; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!mem.req_ready || mem.rsp_valid ||
          axi.rready || axi.bready) bad++;
    end
    stray = 0;
    chk("stray ignored", bad, 0);

    // Reset while AR waits on a stalled arready.
    @(negedge clk);
    cfg_ar_d = 100;
    mem.req_valid = 1; mem.req_wen = 0;
    mem.req_addr = 32'h8000_0400;
    @(negedge clk);
    mem.req_valid = 0;
    @(negedge clk);
    chk("mid arvalid", 32'(axi.arvalid), 1);
    @(posedge clk); #2;
    rst = 1; #1;
    chk("rst arvalid drop", 32'(axi.arvalid), 0);
    chk("rst idle", 32'(mem.req_ready), 1);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem.rsp_valid || axi.arvalid) bad++;
    end
    chk("no rsp after rst", bad, 0);
    rv = vecs[0];
    rv.addr = 32'h8000_0404;
    rv.sdata = 32'h7777_1234;
    rv.exp_rdata = 32'h7777_1234;
    run_vec(rv, 9);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
